// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: default operand width and half-adder build styles.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    typedef enum logic [1:0] {
        HA_GATE     = 2'd0,
        HA_DATAFLOW = 2'd1,
        HA_BEHAV    = 2'd2
    } ha_style_e;

endpackage : arith_pkg

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder; STYLE selects how the same function is expressed.
module half_adder_cell
    import arith_pkg::*;
#(
    parameter ha_style_e STYLE = HA_GATE
) (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    if (STYLE == HA_GATE) begin : g_gate
        // Structural form: gate primitives only.
        xor u_xor (s, a, b);
        and u_and (c, a, b);
    end else if (STYLE == HA_DATAFLOW) begin : g_dataflow
        // Dataflow form: continuous assignments.
        assign s = a ^ b;
        assign c = a & b;
    end else begin : g_behav
        // Behavioural form: explicit truth table on the operand pair.
        always_comb begin
            s = 1'b0;
            c = 1'b0;
            case ({a, b})
                2'b00:          ;
                2'b01, 2'b10:   s = 1'b1;
                2'b11:          c = 1'b1;
                default:        ;
            endcase
        end
    end

endmodule : half_adder_cell

// File: rtl/half_adder_triple.sv
// Registered bitwise half adder built three ways in parallel, with a registered disagreement flag.
module half_adder_triple
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] c1,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] s3,
    output logic [WIDTH-1:0] c3,
    output logic             mismatch
);

    logic [WIDTH-1:0] sum_g;
    logic [WIDTH-1:0] carry_g;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] sum_b;
    logic [WIDTH-1:0] carry_b;
    logic             disagree_c;

    // Three independent cells per bit; no carry crosses bit boundaries.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        half_adder_cell #(.STYLE(HA_GATE)) u_gate (
            .a (a[i]),
            .b (b[i]),
            .s (sum_g[i]),
            .c (carry_g[i])
        );
        half_adder_cell #(.STYLE(HA_DATAFLOW)) u_dataflow (
            .a (a[i]),
            .b (b[i]),
            .s (sum_d[i]),
            .c (carry_d[i])
        );
        half_adder_cell #(.STYLE(HA_BEHAV)) u_behav (
            .a (a[i]),
            .b (b[i]),
            .s (sum_b[i]),
            .c (carry_b[i])
        );
    end

    // Any disagreement among the three sum or carry vectors for the current operands.
    always_comb begin
        disagree_c = 1'b0;
        if ((sum_g != sum_d) || (sum_g != sum_b) ||
            (carry_g != carry_d) || (carry_g != carry_b)) begin
            disagree_c = 1'b1;
        end
    end

    // Output registers; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            c1       <= '0;
            s2       <= '0;
            c2       <= '0;
            s3       <= '0;
            c3       <= '0;
            mismatch <= 1'b0;
        end else begin
            s1       <= sum_g;
            c1       <= carry_g;
            s2       <= sum_d;
            c2       <= carry_d;
            s3       <= sum_b;
            c3       <= carry_b;
            mismatch <= disagree_c;
        end
    end

endmodule : half_adder_triple

// File: tb/tb_half_adder_triple.sv
// Randomised self-checking bench for half_adder_triple at WIDTH=1 and WIDTH=4.
module tb_half_adder_triple;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic [0:0] s1_1, c1_1, s2_1, c2_1, s3_1, c3_1;
    logic       mm_1;
    logic [3:0] s1_4, c1_4, s2_4, c2_4, s3_4, c3_4;
    logic       mm_4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    half_adder_triple #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .s1(s1_1), .c1(c1_1), .s2(s2_1), .c2(c2_1), .s3(s3_1), .c3(c3_1),
        .mismatch(mm_1)
    );

    half_adder_triple #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4),
        .s1(s1_4), .c1(c1_4), .s2(s2_4), .c2(c2_4), .s3(s3_4), .c3(c3_4),
        .mismatch(mm_4)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: per bit, sum and carry are the two bits of the integer a[i]+b[i].
    task automatic ref_add(input logic [3:0] x, input logic [3:0] y, input int w,
                           output logic [3:0] s, output logic [3:0] c);
        int t;
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = t >= 2;
        end
    endtask

    task automatic verify(input string tag, input logic r, input logic [0:0] xa1, input logic [0:0] xb1,
                          input logic [3:0] xa4, input logic [3:0] xb4);
        logic [3:0] es1, ec1, es4, ec4;
        ref_add(4'(xa1), 4'(xb1), 1, es1, ec1);
        ref_add(xa4, xb4, 4, es4, ec4);
        if (r) begin
            es1 = '0; ec1 = '0; es4 = '0; ec4 = '0;
        end
        check({tag, "_w1_s1"}, 4'(s1_1), es1);
        check({tag, "_w1_c1"}, 4'(c1_1), ec1);
        check({tag, "_w1_s2"}, 4'(s2_1), es1);
        check({tag, "_w1_c2"}, 4'(c2_1), ec1);
        check({tag, "_w1_s3"}, 4'(s3_1), es1);
        check({tag, "_w1_c3"}, 4'(c3_1), ec1);
        check({tag, "_w1_mm"}, 4'(mm_1), 4'd0);
        check({tag, "_w4_s1"}, s1_4, es4);
        check({tag, "_w4_c1"}, c1_4, ec4);
        check({tag, "_w4_s2"}, s2_4, es4);
        check({tag, "_w4_c2"}, c2_4, ec4);
        check({tag, "_w4_s3"}, s3_4, es4);
        check({tag, "_w4_c3"}, c3_4, ec4);
        check({tag, "_w4_mm"}, 4'(mm_4), 4'd0);
    endtask

    // Drive on the falling edge, then check just after the following rising edge.
    task automatic apply(input string tag, input logic r, input logic [0:0] xa1, input logic [0:0] xb1,
                         input logic [3:0] xa4, input logic [3:0] xb4);
        @(negedge clk);
        rst = r; a1 = xa1; b1 = xb1; a4 = xa4; b4 = xb4;
        @(posedge clk);
        #1;
        verify(tag, r, xa1, xb1, xa4, xb4);
    endtask

    initial begin
        logic       rr;
        logic [0:0] ra1, rb1;
        logic [3:0] ra4, rb4;
        logic [1:0] pair;

        rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;

        // Reset held two cycles with all operands high.
        apply("rst0", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        apply("rst1", 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);

        // Exhaustive single-bit truth table.
        for (int p = 0; p < 4; p++) begin
            pair = 2'(p);
            apply("tt", 1'b0, pair[1], pair[0], {2'b00, pair}, {pair, 2'b00});
        end

        // Latency: outputs hold until the next rising edge after an operand change.
        apply("lat_pre", 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        @(negedge clk);
        a1 = 1'b1;
        #1;
        check("lat_hold_s1", 4'(s1_1), 4'd1);
        check("lat_hold_c1", 4'(c1_1), 4'd0);
        @(posedge clk);
        #1;
        verify("lat_post", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        check("lat_post_c3", 4'(c3_1), 4'd1);

        // Reset in the middle of a stream, then recovery.
        apply("mid_pre", 1'b0, 1'b1, 1'b0, 4'h5, 4'h3);
        apply("mid_rst", 1'b1, 1'b1, 1'b0, 4'h5, 4'h3);
        apply("mid_post", 1'b0, 1'b1, 1'b0, 4'h5, 4'h3);

        // Four-bit directed vector.
        apply("vec4", 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010);
        check("vec4_s2_const", s2_4, 4'b0110);
        check("vec4_c3_const", c3_4, 4'b1000);

        // Randomised stream with occasional resets.
        for (int n = 0; n < 300; n++) begin
            rr  = ($urandom_range(0, 15) == 0);
            ra1 = 1'($urandom);
            rb1 = 1'($urandom);
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            apply("rnd", rr, ra1, rb1, ra4, rb4);
        end

        // Fault injection: corrupt the gate-level sum and expect the flag for exactly the forced period.
        apply("flt_pre", 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        force dut1.sum_g = 1'b0;
        @(posedge clk);
        #1;
        check("flt_mm", 4'(mm_1), 4'd1);
        check("flt_s1", 4'(s1_1), 4'd0);
        check("flt_s2", 4'(s2_1), 4'd1);
        @(negedge clk);
        release dut1.sum_g;
        @(posedge clk);
        #1;
        check("flt_clr_mm", 4'(mm_1), 4'd0);
        check("flt_clr_s1", 4'(s1_1), 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_half_adder_triple
